// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the tt_uart_tx transmitter.
//   state_e       : FSM state encoding (3 bits)
//   DATA_BITS     : data bits per frame
//   frame_cycles(): clk cycles per complete frame for a given configuration
package tt_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int unsigned DATA_BITS = 8;

  // Total line time of one frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits);
    return (1 + DATA_BITS + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter for the UART transmitter.
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   i_clr    : hold the count at zero
//   o_tick_c : combinational, high in the last cycle of each bit time
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick_c = (r_cnt == CNT_MAX);

  // Counter wraps on tick so every bit advance starts a fresh bit time.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tt_uart_tx.sv
// Byte-wide UART transmitter: one byte per valid/ready handshake, LSB first,
// optional parity, 1 or 2 stop bits. The tile wrapper maps tx to uo_out[0]
// and busy to uo_out[1].
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   ena      : tile enable; low blocks new bytes, the current frame finishes
//   tx_data  : byte to send
//   tx_valid : tx_data is valid
//   tx_ready : combinational; a byte can be accepted this cycle
//   tx       : registered serial line, idle high
//   busy     : registered; frame in progress (start through last stop)
module tt_uart_tx
  import tt_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic PAR_ODD   = 1'(PARITY_ODD);

  state_e               r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_nxt;
  logic                 r_parity, w_parity_nxt;
  logic                 r_stop_idx, w_stop_idx_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 w_tick;
  logic                 w_accept;

  assign tx_ready = (r_state == IDLE) & ena & rst_n;
  assign w_accept = tx_ready & tx_valid;
  assign tx       = r_tx;
  assign busy     = r_busy;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (r_state == IDLE),
    .o_tick_c(w_tick)
  );

  // Next-state logic; the line level for the upcoming bit is decided here
  // and registered alongside the state so tx never comes from a decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_parity_nxt   = r_parity;
    w_stop_idx_nxt = r_stop_idx;
    w_tx_nxt       = r_tx;
    w_busy_nxt     = r_busy;

    case (r_state)
      IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (w_accept) begin
          w_state_nxt    = START;
          w_shift_nxt    = tx_data;
          w_parity_nxt   = (^tx_data) ^ PAR_ODD;
          w_bit_idx_nxt  = '0;
          w_stop_idx_nxt = 1'b0;
          w_tx_nxt       = 1'b0;
          w_busy_nxt     = 1'b1;
        end
      end

      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end
      end

      DATA: begin
        if (w_tick) begin
          if (r_bit_idx == IDX_LAST) begin
            w_stop_idx_nxt = 1'b0;
            if (PARITY_EN != 0) begin
              w_state_nxt = PARITY;
              w_tx_nxt    = r_parity;
            end else begin
              w_state_nxt = STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
            w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
            w_tx_nxt      = r_shift[1];
          end
        end
      end

      PARITY: begin
        if (w_tick) begin
          w_state_nxt    = STOP;
          w_stop_idx_nxt = 1'b0;
          w_tx_nxt       = 1'b1;
        end
      end

      STOP: begin
        w_tx_nxt = 1'b1;
        if (w_tick) begin
          if (r_stop_idx == STOP_LAST) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
          end else begin
            w_stop_idx_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any frame and returns the line to idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_parity   <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_parity   <= w_parity_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_tt_uart_tx.sv
// Bench for tt_uart_tx: one 8N1 instance and one 8E2 instance, both with
// 4 clocks per bit, checked every cycle against a frame-level model.
module tb_tt_uart_tx;
  import tt_uart_pkg::*;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ena = 2'b00;
  logic [1:0] valid = 2'b00;
  logic [7:0] data [2];
  logic       ready0, ready1, tx0, tx1, busy0, busy1;

  always #5 clk = ~clk;

  tt_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena[0]), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready0), .tx(tx0), .busy(busy0));

  tt_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena[1]), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready1), .tx(tx1), .busy(busy1));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is a list of line levels, each held CPB cycles.
  int          m_pe [2];
  int          m_sb [2];
  logic [11:0] m_bits [2];
  int          m_pos [2];
  bit          m_busy [2];
  bit          m_acc [2];
  int          m_len [2];

  initial begin
    m_pe[0] = 0; m_sb[0] = 1;
    m_pe[1] = 1; m_sb[1] = 2;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_pos[i] = 0; m_acc[i] = 1'b0; m_bits[i] = '1; data[i] = 8'h00;
      m_len[i] = int'(frame_cycles(CPB, m_pe[i], m_sb[i]));
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 1'b0;
      if (!rst_n) begin
        m_busy[i] = 1'b0;
        m_pos[i]  = 0;
      end else if (m_busy[i]) begin
        m_pos[i]++;
        if (m_pos[i] == m_len[i]) m_busy[i] = 1'b0;
      end else if (ena[i] && valid[i]) begin
        m_bits[i]      = '1;
        m_bits[i][0]   = 1'b0;
        m_bits[i][8:1] = data[i];
        if (m_pe[i] != 0) m_bits[i][9] = ^data[i];
        m_busy[i] = 1'b1;
        m_pos[i]  = 0;
        m_acc[i]  = 1'b1;
      end
    end
  end

  task automatic cmp(input int i, input logic a_tx, input logic a_busy, input logic a_ready);
    logic e_tx;
    e_tx = m_busy[i] ? m_bits[i][m_pos[i] / CPB] : 1'b1;
    check($sformatf("tx%0d", i), int'(a_tx), int'(e_tx));
    check($sformatf("busy%0d", i), int'(a_busy), int'(m_busy[i]));
    check($sformatf("ready%0d", i), int'(a_ready), int'(!m_busy[i] && ena[i] && rst_n));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, tx0, busy0, ready0);
      cmp(1, tx1, busy1, ready1);
    end
  end

  function automatic logic tx_of(input int i);
    return (i == 0) ? tx0 : tx1;
  endfunction

  function automatic logic busy_of(input int i);
    return (i == 0) ? busy0 : busy1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a byte and wait (bounded) for the handshake edge.
  task automatic send(input int i, input logic [7:0] b, input bit keep, output int waited);
    data[i]  = b;
    valid[i] = 1'b1;
    waited   = 0;
    do begin
      step();
      waited++;
    end while (!m_acc[i] && waited < 300);
    if (!m_acc[i]) check("send_timeout", 0, 1);
    if (!keep) valid[i] = 1'b0;
  endtask

  // Sample the middle of every bit and count busy cycles of the frame.
  task automatic capture(input int i, input int nbits, input int len,
                         output logic [11:0] pat, output int bcnt);
    pat  = '0;
    bcnt = 0;
    for (int j = 0; j < len + 3; j++) begin
      @(negedge clk);
      if ((j % CPB) == 2 && (j / CPB) < nbits) pat[j / CPB] = tx_of(i);
      if (busy_of(i)) bcnt++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] pat;
    int bc, w;

    // Reset with ena high: ready must still be held low
    ena = 2'b11;
    step();
    chk_en = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_tx0", int'(tx0), 1);
    check("rst_busy0", int'(busy0), 0);
    check("rst_ready0", int'(ready0), 0);
    check("rst_ready1", int'(ready1), 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready0", int'(ready0), 1);
    check("rel_ready1", int'(ready1), 1);

    // 0xA5, 8N1
    send(0, 8'hA5, 1'b0, w);
    capture(0, 10, 40, pat, bc);
    check("a5_pattern", int'(pat), 12'h34A);
    check("a5_busy_cycles", bc, 40);

    // 0x07, even parity, two stop bits
    send(1, 8'h07, 1'b0, w);
    capture(1, 12, 48, pat, bc);
    check("07_pattern", int'(pat), 12'hE0E);
    check("07_busy_cycles", bc, 48);

    // Back-to-back with valid held: one ready cycle between frames
    send(0, 8'h55, 1'b1, w);
    send(0, 8'hFF, 1'b0, w);
    check("b2b_gap", w, 41);
    repeat (45) step();

    // ena drops mid-frame; pending byte waits for ena
    send(0, 8'h3C, 1'b0, w);
    repeat (9) step();
    ena[0]   = 1'b0;
    data[0]  = 8'h81;
    valid[0] = 1'b1;
    repeat (36) step();
    check("ena_low_busy", int'(busy0), 0);
    check("ena_low_ready", int'(ready0), 0);
    check("ena_low_tx", int'(tx0), 1);
    ena[0] = 1'b1;
    send(0, 8'h81, 1'b0, w);
    check("ena_resume_wait", w, 1);
    capture(0, 10, 40, pat, bc);
    check("81_pattern", int'(pat), 12'h302);

    // Reset mid-frame aborts; next frame is clean
    send(0, 8'h00, 1'b0, w);
    repeat (16) step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("abort_tx", int'(tx0), 1);
    check("abort_busy", int'(busy0), 0);
    step();
    rst_n = 1'b1;
    send(0, 8'h12, 1'b0, w);
    capture(0, 10, 40, pat, bc);
    check("12_pattern", int'(pat), 12'h224);
    check("12_busy_cycles", bc, 40);

    // Random traffic, source holds each byte until it is taken
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (m_acc[i] || !valid[i]) begin
          valid[i] = ($urandom % 3) == 0;
          data[i]  = 8'($urandom);
        end
        ena[i] = ($urandom % 12) != 0;
      end
      rst_n = ($urandom % 600) != 0;
    end

    valid = 2'b00;
    ena   = 2'b11;
    rst_n = 1'b1;
    repeat (60) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
